// File: rtl/rob_commit_unit.sv
// Commit stage: retires the ROB head into the register files, sequences MMIO/irrevocable
// ops with the LSU, raises traps/xRETs to the CSR unit, and issues the pipeline flush.
module rob_commit_unit #(
   parameter int XLEN   = 64,
   parameter int ITAG_W = 8
) (
   input  logic              clk_i,
   input  logic              arst_n_i,
   input  logic [XLEN-1:0]   rob_data_i,
   input  logic [XLEN-1:0]   rob_csrdata_i,
   input  logic [XLEN-1:0]   rob_branchaddr_i,
   input  logic [XLEN-1:0]   rob_pc_i,
   input  logic              rob_jump_i,
   input  logic [4:0]        rob_fflag_i,
   input  logic              rob_mmio_i,
   input  logic              rob_instr_pageflt_i,
   input  logic              rob_instr_accflt_i,
   input  logic              rob_instr_addrmis_i,
   input  logic              rob_load_addr_mis_i,
   input  logic              rob_store_addr_mis_i,
   input  logic              rob_load_page_flt_i,
   input  logic              rob_store_page_flt_i,
   input  logic              rob_load_acc_flt_i,
   input  logic              rob_store_acc_flt_i,
   input  logic [4:0]        rob_opcode_i,
   input  logic              rob_mret_i,
   input  logic              rob_sret_i,
   input  logic              rob_illins_i,
   input  logic              rob_ecall_i,
   input  logic              rob_ebreak_i,
   input  logic              rob_irrevo_i,
   input  logic [4:0]        rob_rdindex_i,
   input  logic              rob_rden_i,
   input  logic [4:0]        rob_frdindex_i,
   input  logic              rob_frden_i,
   input  logic [11:0]       rob_csrindex_i,
   input  logic              rob_csren_i,
   input  logic              rob_fflagen_i,
   input  logic [2:0]        rob_branchtype_i,
   input  logic [ITAG_W-1:0] rob_itag_i,
   input  logic              rob_complete_i,
   input  logic              rob_valid_i,
   output logic              rob_ready_o,
   output logic              gpr_we_o,
   output logic [4:0]        gpr_idx_o,
   output logic [XLEN-1:0]   gpr_data_o,
   output logic              fpr_we_o,
   output logic [4:0]        fpr_idx_o,
   output logic [XLEN-1:0]   fpr_data_o,
   output logic              csr_we_o,
   output logic [11:0]       csr_idx_o,
   output logic [XLEN-1:0]   csr_data_o,
   output logic              fflag_we_o,
   output logic [4:0]        fflag_o,
   output logic              irrevo_go_o,
   output logic [ITAG_W-1:0] irrevo_itag_o,
   input  logic              irrevo_done_i,
   output logic              trap_req_o,
   output logic [4:0]        trap_cause_o,
   output logic              trap_mret_o,
   output logic              trap_sret_o,
   output logic [XLEN-1:0]   trap_pc_o,
   output logic [XLEN-1:0]   trap_tval_o,
   input  logic              trap_ack_i,
   input  logic [XLEN-1:0]   trap_target_i,
   output logic              flush_o,
   output logic [XLEN-1:0]   redirect_pc_o,
   output logic              instret_o,
   output logic [1:0]        dbg_state_o
);

   // Handshake: the head is consumed in exactly the cycle where rob_valid_i && rob_ready_o;
   // go/trap_req are level requests held until irrevo_done_i/trap_ack_i respectively.
   typedef enum logic [1:0] {S_IDLE, S_WAIT_IRREVO, S_WAIT_TRAP, S_FLUSH} state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [ITAG_W-1:0] r_itag;
   logic [4:0]        r_cause;
   logic              r_mret;
   logic              r_sret;
   logic [XLEN-1:0]   r_trap_pc;
   logic [XLEN-1:0]   r_tval;
   logic              r_trap_retires;
   logic [XLEN-1:0]   r_redirect;

   logic            w_eligible;
   logic            w_exc;
   logic            w_xret;
   logic            w_irrevo;
   logic            w_retire;
   logic            w_trap_done;
   logic            w_enter_trap;
   logic            w_enter_irrevo;
   logic [4:0]      w_cause;
   logic [XLEN-1:0] w_tval;
   logic            w_unused;

   assign w_unused = ^{rob_opcode_i, rob_branchtype_i};

   assign w_eligible = rob_valid_i && rob_complete_i;
   assign w_exc = rob_instr_pageflt_i | rob_instr_accflt_i | rob_instr_addrmis_i |
                  rob_load_addr_mis_i | rob_store_addr_mis_i | rob_load_page_flt_i |
                  rob_store_page_flt_i | rob_load_acc_flt_i | rob_store_acc_flt_i |
                  rob_illins_i | rob_ecall_i | rob_ebreak_i;
   assign w_xret   = rob_mret_i | rob_sret_i;
   assign w_irrevo = rob_irrevo_i | rob_mmio_i;

   assign w_enter_trap   = (r_state == S_IDLE) && w_eligible && (w_exc || w_xret);
   assign w_enter_irrevo = (r_state == S_IDLE) && w_eligible && !w_exc && !w_xret && w_irrevo;

   // Gated by reset so nothing retires combinationally while reset is held.
   assign w_retire = arst_n_i && w_eligible &&
                     (((r_state == S_IDLE) && !w_exc && !w_xret && !w_irrevo) ||
                      ((r_state == S_WAIT_IRREVO) && irrevo_done_i));
   assign w_trap_done = arst_n_i && (r_state == S_WAIT_TRAP) && trap_ack_i;

   // Instruction-side faults outrank decode faults, which outrank data-side faults.
   always_comb begin
      w_cause = 5'd0;
      w_tval  = '0;
      if (rob_instr_pageflt_i) begin
         w_cause = 5'd12; w_tval = rob_pc_i;
      end else if (rob_instr_accflt_i) begin
         w_cause = 5'd1;  w_tval = rob_pc_i;
      end else if (rob_instr_addrmis_i) begin
         w_cause = 5'd0;  w_tval = rob_pc_i;
      end else if (rob_illins_i) begin
         w_cause = 5'd2;
      end else if (rob_ebreak_i) begin
         w_cause = 5'd3;
      end else if (rob_ecall_i) begin
         w_cause = 5'd8;
      end else if (rob_load_addr_mis_i) begin
         w_cause = 5'd4;  w_tval = rob_data_i;
      end else if (rob_store_addr_mis_i) begin
         w_cause = 5'd6;  w_tval = rob_data_i;
      end else if (rob_load_page_flt_i) begin
         w_cause = 5'd13; w_tval = rob_data_i;
      end else if (rob_store_page_flt_i) begin
         w_cause = 5'd15; w_tval = rob_data_i;
      end else if (rob_load_acc_flt_i) begin
         w_cause = 5'd5;  w_tval = rob_data_i;
      end else if (rob_store_acc_flt_i) begin
         w_cause = 5'd7;  w_tval = rob_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) r_state <= S_IDLE;
      else           r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_enter_trap)                  w_next_state = S_WAIT_TRAP;
            else if (w_enter_irrevo)           w_next_state = S_WAIT_IRREVO;
            else if (w_retire && rob_jump_i)   w_next_state = S_FLUSH;
         end
         S_WAIT_IRREVO: begin
            if (irrevo_done_i) w_next_state = (w_retire && rob_jump_i) ? S_FLUSH : S_IDLE;
         end
         S_WAIT_TRAP: begin
            if (trap_ack_i) w_next_state = S_FLUSH;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_itag         <= '0;
         r_cause        <= '0;
         r_mret         <= 1'b0;
         r_sret         <= 1'b0;
         r_trap_pc      <= '0;
         r_tval         <= '0;
         r_trap_retires <= 1'b0;
         r_redirect     <= '0;
      end else begin
         if (w_enter_irrevo) r_itag <= rob_itag_i;
         if (w_enter_trap) begin
            r_cause        <= w_exc ? w_cause : 5'd0;
            r_mret         <= !w_exc && rob_mret_i;
            r_sret         <= !w_exc && rob_sret_i;
            r_trap_pc      <= rob_pc_i;
            r_tval         <= w_exc ? w_tval : '0;
            r_trap_retires <= w_xret | rob_ecall_i | rob_ebreak_i;
         end
         if (w_retire && rob_jump_i) r_redirect <= rob_branchaddr_i;
         if (w_trap_done)            r_redirect <= trap_target_i;
      end
   end

   always_comb begin
      rob_ready_o   = w_retire || (w_trap_done && rob_valid_i);
      instret_o     = w_retire || (w_trap_done && r_trap_retires);
      gpr_we_o      = w_retire && rob_rden_i;
      gpr_idx_o     = gpr_we_o ? rob_rdindex_i : 5'd0;
      gpr_data_o    = gpr_we_o ? rob_data_i : '0;
      fpr_we_o      = w_retire && rob_frden_i;
      fpr_idx_o     = fpr_we_o ? rob_frdindex_i : 5'd0;
      fpr_data_o    = fpr_we_o ? rob_data_i : '0;
      csr_we_o      = w_retire && rob_csren_i;
      csr_idx_o     = csr_we_o ? rob_csrindex_i : 12'd0;
      csr_data_o    = csr_we_o ? rob_csrdata_i : '0;
      fflag_we_o    = w_retire && rob_fflagen_i;
      fflag_o       = fflag_we_o ? rob_fflag_i : 5'd0;
      irrevo_go_o   = (r_state == S_WAIT_IRREVO);
      irrevo_itag_o = irrevo_go_o ? r_itag : '0;
      trap_req_o    = (r_state == S_WAIT_TRAP);
      trap_cause_o  = trap_req_o ? r_cause : 5'd0;
      trap_mret_o   = trap_req_o && r_mret;
      trap_sret_o   = trap_req_o && r_sret;
      trap_pc_o     = trap_req_o ? r_trap_pc : '0;
      trap_tval_o   = trap_req_o ? r_tval : '0;
      flush_o       = (r_state == S_FLUSH);
      redirect_pc_o = flush_o ? r_redirect : '0;
      dbg_state_o   = r_state;
   end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Self-checking bench for rob_commit_unit: directed scenarios plus random transactions
// checked against a transaction-level model of the commit rules.
module tb_rob_commit_unit;
   localparam int XLEN   = 64;
   localparam int ITAG_W = 8;

   logic clk_i = 1'b0;
   logic arst_n_i;
   logic [XLEN-1:0] rob_data_i, rob_csrdata_i, rob_branchaddr_i, rob_pc_i;
   logic rob_jump_i, rob_mmio_i;
   logic [4:0] rob_fflag_i, rob_opcode_i, rob_rdindex_i, rob_frdindex_i;
   logic rob_instr_pageflt_i, rob_instr_accflt_i, rob_instr_addrmis_i;
   logic rob_load_addr_mis_i, rob_store_addr_mis_i, rob_load_page_flt_i;
   logic rob_store_page_flt_i, rob_load_acc_flt_i, rob_store_acc_flt_i;
   logic rob_mret_i, rob_sret_i, rob_illins_i, rob_ecall_i, rob_ebreak_i, rob_irrevo_i;
   logic rob_rden_i, rob_frden_i, rob_csren_i, rob_fflagen_i, rob_complete_i, rob_valid_i;
   logic [11:0] rob_csrindex_i;
   logic [2:0] rob_branchtype_i;
   logic [ITAG_W-1:0] rob_itag_i;
   logic rob_ready_o, gpr_we_o, fpr_we_o, csr_we_o, fflag_we_o;
   logic [4:0] gpr_idx_o, fpr_idx_o, fflag_o, trap_cause_o;
   logic [XLEN-1:0] gpr_data_o, fpr_data_o, csr_data_o, trap_pc_o, trap_tval_o;
   logic [XLEN-1:0] trap_target_i, redirect_pc_o;
   logic [11:0] csr_idx_o;
   logic irrevo_go_o, irrevo_done_i, trap_req_o, trap_mret_o, trap_sret_o, trap_ack_i;
   logic flush_o, instret_o;
   logic [ITAG_W-1:0] irrevo_itag_o;
   logic [1:0] dbg_state_o;

   rob_commit_unit #(.XLEN(XLEN), .ITAG_W(ITAG_W)) dut (
      .clk_i(clk_i), .arst_n_i(arst_n_i),
      .rob_data_i(rob_data_i), .rob_csrdata_i(rob_csrdata_i),
      .rob_branchaddr_i(rob_branchaddr_i), .rob_pc_i(rob_pc_i), .rob_jump_i(rob_jump_i),
      .rob_fflag_i(rob_fflag_i), .rob_mmio_i(rob_mmio_i),
      .rob_instr_pageflt_i(rob_instr_pageflt_i), .rob_instr_accflt_i(rob_instr_accflt_i),
      .rob_instr_addrmis_i(rob_instr_addrmis_i), .rob_load_addr_mis_i(rob_load_addr_mis_i),
      .rob_store_addr_mis_i(rob_store_addr_mis_i), .rob_load_page_flt_i(rob_load_page_flt_i),
      .rob_store_page_flt_i(rob_store_page_flt_i), .rob_load_acc_flt_i(rob_load_acc_flt_i),
      .rob_store_acc_flt_i(rob_store_acc_flt_i), .rob_opcode_i(rob_opcode_i),
      .rob_mret_i(rob_mret_i), .rob_sret_i(rob_sret_i), .rob_illins_i(rob_illins_i),
      .rob_ecall_i(rob_ecall_i), .rob_ebreak_i(rob_ebreak_i), .rob_irrevo_i(rob_irrevo_i),
      .rob_rdindex_i(rob_rdindex_i), .rob_rden_i(rob_rden_i),
      .rob_frdindex_i(rob_frdindex_i), .rob_frden_i(rob_frden_i),
      .rob_csrindex_i(rob_csrindex_i), .rob_csren_i(rob_csren_i),
      .rob_fflagen_i(rob_fflagen_i), .rob_branchtype_i(rob_branchtype_i),
      .rob_itag_i(rob_itag_i), .rob_complete_i(rob_complete_i), .rob_valid_i(rob_valid_i),
      .rob_ready_o(rob_ready_o),
      .gpr_we_o(gpr_we_o), .gpr_idx_o(gpr_idx_o), .gpr_data_o(gpr_data_o),
      .fpr_we_o(fpr_we_o), .fpr_idx_o(fpr_idx_o), .fpr_data_o(fpr_data_o),
      .csr_we_o(csr_we_o), .csr_idx_o(csr_idx_o), .csr_data_o(csr_data_o),
      .fflag_we_o(fflag_we_o), .fflag_o(fflag_o),
      .irrevo_go_o(irrevo_go_o), .irrevo_itag_o(irrevo_itag_o), .irrevo_done_i(irrevo_done_i),
      .trap_req_o(trap_req_o), .trap_cause_o(trap_cause_o), .trap_mret_o(trap_mret_o),
      .trap_sret_o(trap_sret_o), .trap_pc_o(trap_pc_o), .trap_tval_o(trap_tval_o),
      .trap_ack_i(trap_ack_i), .trap_target_i(trap_target_i),
      .flush_o(flush_o), .redirect_pc_o(redirect_pc_o), .instret_o(instret_o),
      .dbg_state_o(dbg_state_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [63:0] data, csrdata, baddr, pc;
      logic        jump, mmio, irrevo;
      logic [4:0]  fflag;
      logic        ipf, iaf, iam, lam, sam, lpf, spf, laf, saf;
      logic        mret, sret, illins, ecall, ebreak;
      logic [4:0]  rd, frd;
      logic        rden, frden, csren, fflagen;
      logic [11:0] csri;
      logic [7:0]  itag;
   } entry_t;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   function automatic entry_t blank();
      entry_t e;
      e = '{default: '0};
      return e;
   endfunction

   function automatic entry_t plain_entry();
      entry_t e;
      e = blank();
      e.data = rand64(); e.csrdata = rand64(); e.baddr = rand64(); e.pc = rand64();
      e.jump = ($urandom_range(0, 3) == 0);
      e.fflag = 5'($urandom_range(0, 31));
      e.rd = 5'($urandom_range(0, 31)); e.frd = 5'($urandom_range(0, 31));
      e.rden = 1'($urandom_range(0, 1)); e.frden = 1'($urandom_range(0, 1));
      e.csren = 1'($urandom_range(0, 1)); e.fflagen = 1'($urandom_range(0, 1));
      e.csri = 12'($urandom_range(0, 4095)); e.itag = 8'($urandom_range(0, 255));
      return e;
   endfunction

   function automatic entry_t rand_entry();
      entry_t e;
      e = plain_entry();
      e.mmio = ($urandom_range(0, 7) == 0);  e.irrevo = ($urandom_range(0, 9) == 0);
      e.ipf = ($urandom_range(0, 24) == 0);  e.iaf = ($urandom_range(0, 24) == 0);
      e.iam = ($urandom_range(0, 24) == 0);  e.lam = ($urandom_range(0, 24) == 0);
      e.sam = ($urandom_range(0, 24) == 0);  e.lpf = ($urandom_range(0, 24) == 0);
      e.spf = ($urandom_range(0, 24) == 0);  e.laf = ($urandom_range(0, 24) == 0);
      e.saf = ($urandom_range(0, 24) == 0);  e.illins = ($urandom_range(0, 29) == 0);
      e.ecall = ($urandom_range(0, 29) == 0); e.ebreak = ($urandom_range(0, 29) == 0);
      e.mret = ($urandom_range(0, 24) == 0); e.sret = ($urandom_range(0, 24) == 0);
      return e;
   endfunction

   task automatic drive(input entry_t e, input logic v, input logic c);
      rob_data_i = e.data; rob_csrdata_i = e.csrdata; rob_branchaddr_i = e.baddr;
      rob_pc_i = e.pc; rob_jump_i = e.jump; rob_fflag_i = e.fflag; rob_mmio_i = e.mmio;
      rob_instr_pageflt_i = e.ipf; rob_instr_accflt_i = e.iaf; rob_instr_addrmis_i = e.iam;
      rob_load_addr_mis_i = e.lam; rob_store_addr_mis_i = e.sam;
      rob_load_page_flt_i = e.lpf; rob_store_page_flt_i = e.spf;
      rob_load_acc_flt_i = e.laf; rob_store_acc_flt_i = e.saf;
      rob_mret_i = e.mret; rob_sret_i = e.sret; rob_illins_i = e.illins;
      rob_ecall_i = e.ecall; rob_ebreak_i = e.ebreak; rob_irrevo_i = e.irrevo;
      rob_rdindex_i = e.rd; rob_rden_i = e.rden; rob_frdindex_i = e.frd; rob_frden_i = e.frden;
      rob_csrindex_i = e.csri; rob_csren_i = e.csren; rob_fflagen_i = e.fflagen;
      rob_itag_i = e.itag; rob_opcode_i = 5'($urandom_range(0, 31));
      rob_branchtype_i = 3'($urandom_range(0, 7));
      rob_valid_i = v; rob_complete_i = c;
   endtask

   // Reference: walk the cause table from lowest to highest priority; the last hit wins.
   task automatic model_trap(input entry_t e, output logic [4:0] cause,
                             output logic [63:0] tval);
      logic hit[12];
      int   code[12];
      int   src[12];
      hit  = '{e.ipf, e.iaf, e.iam, e.illins, e.ebreak, e.ecall,
               e.lam, e.sam, e.lpf, e.spf, e.laf, e.saf};
      code = '{12, 1, 0, 2, 3, 8, 4, 6, 13, 15, 5, 7};
      src  = '{1, 1, 1, 0, 0, 0, 2, 2, 2, 2, 2, 2};
      cause = 5'd0;
      tval  = '0;
      for (int i = 11; i >= 0; i--) begin
         if (hit[i]) begin
            cause = 5'(code[i]);
            tval  = (src[i] == 1) ? e.pc : (src[i] == 2) ? e.data : 64'd0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_retire(input entry_t e, input string tag);
      check({tag, ":ready"}, rob_ready_o, 1);
      check({tag, ":instret"}, instret_o, 1);
      check({tag, ":gpr_we"}, gpr_we_o, e.rden);
      if (e.rden) begin
         check({tag, ":gpr_idx"}, gpr_idx_o, e.rd);
         check({tag, ":gpr_data"}, gpr_data_o, e.data);
      end
      check({tag, ":fpr_we"}, fpr_we_o, e.frden);
      if (e.frden) check({tag, ":fpr_data"}, {fpr_idx_o, fpr_data_o[58:0]}, {e.frd, e.data[58:0]});
      check({tag, ":csr_we"}, csr_we_o, e.csren);
      if (e.csren) check({tag, ":csr"}, {csr_idx_o, csr_data_o[51:0]}, {e.csri, e.csrdata[51:0]});
      check({tag, ":fflag_we"}, fflag_we_o, e.fflagen);
      if (e.fflagen) check({tag, ":fflag"}, fflag_o, e.fflag);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ":quiet"}, {rob_ready_o, instret_o, gpr_we_o, fpr_we_o, csr_we_o, fflag_we_o}, 0);
   endtask

   // Entered at posedge+1 with state idle; leaves at posedge+1 with state idle, inputs blank.
   task automatic flush_tail(input logic exp_flush, input logic [63:0] exp_pc, input string tag);
      if (exp_flush) drive(plain_entry(), 1'b1, 1'b1);
      else           drive(blank(), 1'b0, 1'b0);
      #1;
      check({tag, ":flush"}, flush_o, exp_flush);
      if (exp_flush) begin
         check({tag, ":redirect"}, redirect_pc_o, exp_pc);
         check_quiet({tag, ":in_flush"});
         tick();
         drive(blank(), 1'b0, 1'b0);
         #1;
         check({tag, ":flush_1cyc"}, flush_o, 0);
      end
      check({tag, ":idle"}, dbg_state_o, 0);
   endtask

   task automatic run_txn(input entry_t e, input int wait_n, input logic [63:0] tgt,
                          input string tag);
      logic        exc, xr;
      logic [4:0]  cause;
      logic [63:0] tval;
      exc = e.ipf | e.iaf | e.iam | e.lam | e.sam | e.lpf | e.spf | e.laf | e.saf |
            e.illins | e.ecall | e.ebreak;
      xr  = e.mret | e.sret;
      model_trap(e, cause, tval);
      drive(e, 1'b1, 1'b1);
      #1;
      if (exc || xr) begin
         check_quiet({tag, ":trap_issue"});
         tick(); #1;
         check({tag, ":trap_req"}, trap_req_o, 1);
         check({tag, ":trap_info"}, {trap_cause_o, trap_mret_o, trap_sret_o},
               {cause, !exc && e.mret, !exc && e.sret});
         check({tag, ":trap_pc"}, trap_pc_o, e.pc);
         check({tag, ":trap_tval"}, trap_tval_o, tval);
         check_quiet({tag, ":trap_wait0"});
         for (int i = 0; i < wait_n; i++) begin
            tick(); #1;
            check({tag, ":trap_hold"}, {trap_req_o, trap_cause_o}, {1'b1, cause});
            check_quiet({tag, ":trap_wait"});
         end
         tick();
         trap_ack_i = 1'b1;
         trap_target_i = tgt;
         #1;
         check({tag, ":ack_ready"}, rob_ready_o, 1);
         check({tag, ":ack_instret"}, instret_o, xr | e.ecall | e.ebreak);
         check({tag, ":ack_nowb"}, {gpr_we_o, fpr_we_o, csr_we_o, fflag_we_o}, 0);
         tick();
         trap_ack_i = 1'b0;
         trap_target_i = rand64();
         flush_tail(1'b1, tgt, tag);
      end else if (e.irrevo || e.mmio) begin
         check_quiet({tag, ":irr_issue"});
         check({tag, ":go_not_yet"}, irrevo_go_o, 0);
         tick(); #1;
         check({tag, ":go"}, {irrevo_go_o, irrevo_itag_o}, {1'b1, e.itag});
         check_quiet({tag, ":irr_wait0"});
         for (int i = 0; i < wait_n; i++) begin
            tick(); #1;
            check({tag, ":go_hold"}, irrevo_go_o, 1);
            check_quiet({tag, ":irr_wait"});
         end
         tick();
         irrevo_done_i = 1'b1;
         e.data = rand64();
         drive(e, 1'b1, 1'b1);
         #1;
         check_retire(e, {tag, ":irr_done"});
         tick();
         irrevo_done_i = 1'b0;
         #1;
         check({tag, ":go_drop"}, irrevo_go_o, 0);
         flush_tail(e.jump, e.baddr, tag);
      end else begin
         check_retire(e, tag);
         tick();
         flush_tail(e.jump, e.baddr, tag);
      end
   endtask

   function automatic logic any_out();
      return |{rob_ready_o, gpr_we_o, gpr_idx_o, gpr_data_o, fpr_we_o, fpr_idx_o, fpr_data_o,
               csr_we_o, csr_idx_o, csr_data_o, fflag_we_o, fflag_o, irrevo_go_o,
               irrevo_itag_o, trap_req_o, trap_cause_o, trap_mret_o, trap_sret_o, trap_pc_o,
               trap_tval_o, flush_o, redirect_pc_o, instret_o};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      entry_t e;
      arst_n_i = 1'b0;
      irrevo_done_i = 1'b0;
      trap_ack_i = 1'b0;
      trap_target_i = '0;
      drive(blank(), 1'b0, 1'b0);
      #2;
      check("reset_outputs", any_out(), 0);
      check("reset_state", dbg_state_o, 0);
      repeat (2) tick();
      arst_n_i = 1'b1;
      tick();

      // ALU op with GPR write
      e = blank();
      e.rden = 1'b1; e.rd = 5'd5; e.data = 64'h1234;
      drive(e, 1'b1, 1'b1);
      #1;
      check("alu:gpr", {gpr_we_o, gpr_idx_o, gpr_data_o[15:0]}, {1'b1, 5'd5, 16'h1234});
      check("alu:ready_instret", {rob_ready_o, instret_o}, 2'b11);
      tick();
      flush_tail(1'b0, 64'd0, "alu");

      // Taken branch
      e = blank();
      e.jump = 1'b1; e.baddr = 64'h8000_0100;
      run_txn(e, 0, 64'd0, "branch");

      // MMIO load, done five cycles after go
      e = blank();
      e.mmio = 1'b1; e.rden = 1'b1; e.rd = 5'd9; e.itag = 8'h5a;
      run_txn(e, 4, 64'd0, "mmio");

      // Load page fault plus load misaligned: misaligned wins
      e = blank();
      e.lpf = 1'b1; e.lam = 1'b1; e.data = 64'h1003; e.rden = 1'b1; e.pc = 64'h2000;
      run_txn(e, 2, 64'h8000_0000, "multiflt");

      // mret
      e = blank();
      e.mret = 1'b1; e.pc = 64'h3000;
      run_txn(e, 1, 64'h4000, "mret");

      // Valid without complete: nothing happens
      e = plain_entry();
      drive(e, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         #1;
         check("nocomplete:ready", {rob_ready_o, instret_o, dbg_state_o}, 0);
         tick();
      end
      drive(blank(), 1'b0, 1'b0);

      // Reset in the middle of WAIT_TRAP
      e = blank();
      e.illins = 1'b1; e.pc = 64'h5000;
      drive(e, 1'b1, 1'b1);
      tick(); #1;
      check("rst_mid:trap_req", {trap_req_o, trap_cause_o}, {1'b1, 5'd2});
      arst_n_i = 1'b0;
      drive(plain_entry(), 1'b1, 1'b1);
      #1;
      check("rst_mid:outputs", any_out(), 0);
      check("rst_mid:state", dbg_state_o, 0);
      drive(blank(), 1'b0, 1'b0);
      tick();
      arst_n_i = 1'b1;
      tick(); #1;
      check("rst_release:state", {dbg_state_o, trap_req_o, flush_o}, 0);

      // Random transactions
      for (int t = 0; t < 300; t++) begin
         run_txn(rand_entry(), $urandom_range(0, 5), rand64(), $sformatf("rnd%0d", t));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Consumer (slave) end of the ROB read port. It takes the ROB head entry once it is valid and complete, and retires it.
- Retirement outputs: GPR/FPR/CSR writeback, accumulated fflags, branch redirect, trap/xRET request to the CSR unit, and the irrevocable-instruction (MMIO/irrevo) go/done handshake with the LSU.
- Generates the pipeline flush and the instret count.
- Sits between the ROB and the register files/CSR unit in the commit stage.

Parameters:
XLEN, 64, data/address width
ITAG_W, 8, instruction tag width

Ports:
clk_i  in  1  clock
arst_n_i  in  1  asynchronous active-low reset
rob_*  in  per field  slave side of the ROB read port: data, csrdata, branchaddr, pc, jump, fflag[4:0], mmio, all fault bits, opcode[4:0], mret, sret, illins, ecall, ebreak, irrevo, rdindex, rden, frdindex, frden, csrindex, csren, fflagen, branchtype[2:0], itag, complete, valid
rob_ready_o  out  1  head entry consumed when rob_valid_i & rob_ready_o
gpr_we_o/gpr_idx_o[4:0]/gpr_data_o[XLEN]  out  integer writeback
fpr_we_o/fpr_idx_o[4:0]/fpr_data_o[XLEN]  out  FP writeback
csr_we_o/csr_idx_o[11:0]/csr_data_o[XLEN]  out  CSR writeback
fflag_we_o/fflag_o[4:0]  out  fflags OR-accumulate request
irrevo_go_o/irrevo_itag_o[ITAG_W]  out  permission to perform the head irrevocable/MMIO op
irrevo_done_i  in  1  LSU finished the irrevocable op
trap_req_o  out  1  trap/xRET request
trap_cause_o[4:0], trap_mret_o, trap_sret_o, trap_pc_o[XLEN], trap_tval_o[XLEN]  out  trap info
trap_ack_i  in  1  CSR unit accepted; trap_target_i valid
trap_target_i[XLEN]  in  redirect target (vector or xepc)
flush_o  out  1  one-cycle pipeline flush
redirect_pc_o[XLEN]  out  valid with flush_o
instret_o  out  1  one instruction retired this cycle

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-operation abandons any pending go/trap.
- Head is eligible when rob_valid_i & rob_complete_i.
- exc = OR of all fault bits | illins | ecall | ebreak. xret = mret | sret.
- States: IDLE, WAIT_IRREVO, WAIT_TRAP, FLUSH.
- IDLE, eligible, no exc/xret, irrevo=0 and mmio=0: retire combinationally in the same cycle.
  - rob_ready_o=1; instret_o=1.
  - gpr_we_o = rden; fpr_we_o = frden; csr_we_o = csren; fflag_we_o = fflagen. Data fields pass through.
  - If jump=1: registered flush_o=1 next cycle, redirect_pc_o=branchaddr, go to FLUSH.
- IDLE, eligible, irrevo|mmio, no exc: registered irrevo_go_o=1 with itag; go to WAIT_IRREVO. rob_ready_o=0.
- WAIT_IRREVO: hold go until irrevo_done_i.
  - On done (ROB has written load data/complete): drop go; retire as above in the same cycle; return to IDLE.
  - Done and go in the same cycle as entry is not possible; go is registered.
- IDLE, eligible, exc or xret: registered trap_req_o=1; go to WAIT_TRAP. No writebacks.
  - trap_pc_o = pc.
  - trap_tval_o = data for load/store faults, pc for instruction faults, 0 otherwise.
- Cause priority, highest first, with code:
  - instr_pageflt 12, instr_accflt 1, instr_addrmis 0, illins 2, ebreak 3, ecall 8 (the CSR unit adds the privilege offset)
  - load_addr_mis 4, store_addr_mis 6, load_page_flt 13, store_page_flt 15, load_acc_flt 5, store_acc_flt 7
  - xret only when exc=0; cause=0, with mret/sret flag set.
- WAIT_TRAP: hold all trap outputs stable until trap_ack_i.
  - On ack: rob_ready_o=1 (consume head); instret_o = xret | ecall | ebreak.
  - flush_o=1 next cycle, redirect_pc_o = trap_target_i sampled at ack; go to FLUSH.
- FLUSH: flush_o=1 for exactly one cycle, rob_ready_o=0; then IDLE.
- Valid without complete: wait; no state change.
- rob_ready_o is never 1 while rob_valid_i=0.
- At most one retirement per cycle.
- A head entry presented during the FLUSH cycle is ignored; the ROB is cleared by flush_o.

Test Plan:
- Reset: arst_n_i=0 mid WAIT_TRAP → all outputs 0 immediately, state IDLE after release.
- ALU op: valid=complete=1, rden=1, rdindex=5, data=0x1234 → same cycle: gpr_we_o=1, idx 5, data 0x1234, ready=1, instret_o=1.
- Taken branch: jump=1, branchaddr=0x8000_0100 → retire cycle, then flush_o=1 for one cycle with redirect_pc_o=0x8000_0100, ready=0 during flush.
- MMIO load: mmio=1 → irrevo_go_o=1 next cycle; irrevo_done_i after 5 cycles → same-cycle retire with GPR write, go drops.
- Multiple faults: load_page_flt=1 and load_addr_mis=1, data=0x1003 → trap_cause_o=4, tval 0x1003, no GPR write. ack with target 0x8000_0000 → flush_o next cycle, redirect 0x8000_0000, instret_o=0.
- mret: trap_mret_o=1, cause 0. ack with target 0x4000 → instret_o=1 at ack, flush to 0x4000. Also: valid=1, complete=0 for 10 cycles → ready held at 0 throughout.
